// File: rtl/balance_writeback_pkg.sv
// Shared transaction definitions for the memory-store writeback path:
// FSM state encoding, RAM field codes and the word record exchanged with RAM.
package balance_writeback_pkg;

  localparam logic [2:0] STEP_STORE = 3'b100;

  localparam logic [1:0] ACC_LOW  = 2'b00;
  localparam logic [1:0] ACC_HIGH = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  // One RAM word: where it lives and which byte of the snapshot belongs there.
  typedef struct packed {
    logic       access_p2;
    logic [1:0] access_type;
    logic [7:0] data;
  } word_t;

endpackage

// File: rtl/balance_writeback_if.sv
// Request, balance and RAM signals of the writeback block, bundled as one bus.
// The slave side is the writeback block; the master side is controller plus RAM.
interface balance_writeback_if;
  logic        start;
  logic [10:0] p1_amount;
  logic [10:0] p2_amount;
  logic        mem_access_p2;
  logic [1:0]  mem_access_type;
  logic [7:0]  mem_data_in;
  logic        mem_wren;
  logic [7:0]  mem_result;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  start, p1_amount, p2_amount, mem_result,
    output mem_access_p2, mem_access_type, mem_data_in, mem_wren,
           busy, done, error
  );

  modport master (
    output start, p1_amount, p2_amount, mem_result,
    input  mem_access_p2, mem_access_type, mem_data_in, mem_wren,
           busy, done, error
  );
endinterface

// File: rtl/writeback_word_mux.sv
// Maps word index 0..3 onto the balance snapshot: RAM address fields plus the
// byte to write, which is also the byte expected on read-back.
module writeback_word_mux
  import balance_writeback_pkg::*;
(
  input  logic [1:0]  i_idx,
  input  logic [10:0] i_p1,
  input  logic [10:0] i_p2,
  output word_t       o_word
);

  logic [10:0] w_amount;

  always_comb begin
    w_amount           = i_idx[1] ? i_p2 : i_p1;
    o_word.access_p2   = i_idx[1];
    o_word.access_type = i_idx[0] ? ACC_HIGH : ACC_LOW;
    o_word.data        = i_idx[0] ? {5'b0, w_amount[10:8]} : w_amount[7:0];
  end

endmodule

// File: rtl/balance_writeback.sv
// Stores both player balances to RAM as two bytes each, reads them back and
// retries the full write on a mismatch before reporting done or error.
module balance_writeback
  import balance_writeback_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_RETRY = 2
) (
  input logic               clock,
  input logic               reset,
  balance_writeback_if.slave bus
);

  localparam logic [1:0] LP_WAIT_LOAD = 2'(RD_LAT - 1);
  localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);

  state_e      r_state, w_state_nxt;
  logic [10:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_wait, w_wait_nxt;
  logic [2:0]  r_retry, w_retry_nxt;
  logic        w_drive_addr;
  logic        w_wren;
  logic        w_match;
  word_t       w_word;

  writeback_word_mux u_word_mux (
    .i_idx  (r_idx),
    .i_p1   (r_p1),
    .i_p2   (r_p2),
    .o_word (w_word)
  );

  assign w_match = (bus.mem_result == w_word.data);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_p1    <= '0;
      r_p2    <= '0;
      r_idx   <= '0;
      r_wait  <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p1    <= w_p1_nxt;
      r_p2    <= w_p2_nxt;
      r_idx   <= w_idx_nxt;
      r_wait  <= w_wait_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_idx_nxt    = r_idx;
    w_wait_nxt   = r_wait;
    w_retry_nxt  = r_retry;
    w_drive_addr = 1'b0;
    w_wren       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_p1_nxt    = bus.p1_amount;
          w_p2_nxt    = bus.p2_amount;
          w_idx_nxt   = 2'd0;
          w_retry_nxt = 3'd0;
          w_state_nxt = ST_WRITE;
        end
      end

      ST_WRITE: begin
        w_drive_addr = 1'b1;
        w_wren       = 1'b1;
        if (!bus.start) begin
          w_state_nxt = ST_IDLE;
        end else if (r_idx == 2'd3) begin
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_RD_ADDR;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end

      ST_RD_ADDR: begin
        w_drive_addr = 1'b1;
        w_wait_nxt   = LP_WAIT_LOAD;
        w_state_nxt  = bus.start ? ST_RD_WAIT : ST_IDLE;
      end

      // The cycle with r_wait == 0 is the one where mem_result is valid.
      ST_RD_WAIT: begin
        w_drive_addr = 1'b1;
        if (!bus.start) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wait != 2'd0) begin
          w_wait_nxt = r_wait - 2'd1;
        end else if (w_match) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = ST_RD_ADDR;
          end
        end else if (r_retry < LP_MAX_RETRY) begin
          w_retry_nxt = r_retry + 3'd1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_ERROR;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (!bus.start) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_wren        = w_wren;
  assign bus.mem_access_p2   = w_drive_addr & w_word.access_p2;
  assign bus.mem_access_type = w_drive_addr ? w_word.access_type : ACC_LOW;
  assign bus.mem_data_in     = w_wren ? w_word.data : 8'h00;
  assign bus.busy            = (r_state != ST_IDLE) && (r_state != ST_DONE) &&
                               (r_state != ST_ERROR);
  assign bus.done            = (r_state == ST_DONE);
  assign bus.error           = (r_state == ST_ERROR);

endmodule

// File: tb/tb_balance_writeback.sv
// Bench for balance_writeback: two instances (RD_LAT 1 / MAX_RETRY 2 and
// RD_LAT 2 / MAX_RETRY 1) against a RAM model with injectable read corruption.
module tb_balance_writeback;

  typedef struct packed {
    logic [15:0] cyc;
    logic        p2;
    logic [1:0]  typ;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [10:0] a1;
    logic [10:0] a2;
    logic [11:0] cm;
    int          exp_done;
    bit          exp_err;
    int          exp_wr;
    logic [31:0] exp_bytes;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        start_v;
  logic [1:0][10:0]  p1_v, p2_v;
  logic [1:0][11:0]  cm_v;
  logic [1:0][7:0]   res_v;
  logic [1:0]        wren_v, ap2_v, busy_v, done_v, err_v;
  logic [1:0][1:0]   atype_v;
  logic [1:0][7:0]   din_v;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t act_q[$];
  wr_t exp_q[$];

  always #5 clock = ~clock;

  balance_writeback_if bus0 ();
  balance_writeback_if bus1 ();

  assign bus0.start      = start_v[0];
  assign bus0.p1_amount  = p1_v[0];
  assign bus0.p2_amount  = p2_v[0];
  assign bus0.mem_result = res_v[0];
  assign bus1.start      = start_v[1];
  assign bus1.p1_amount  = p1_v[1];
  assign bus1.p2_amount  = p2_v[1];
  assign bus1.mem_result = res_v[1];

  assign wren_v  = {bus1.mem_wren, bus0.mem_wren};
  assign ap2_v   = {bus1.mem_access_p2, bus0.mem_access_p2};
  assign busy_v  = {bus1.busy, bus0.busy};
  assign done_v  = {bus1.done, bus0.done};
  assign err_v   = {bus1.error, bus0.error};
  assign atype_v = {bus1.mem_access_type, bus0.mem_access_type};
  assign din_v   = {bus1.mem_data_in, bus0.mem_data_in};

  balance_writeback #(.RD_LAT(1), .MAX_RETRY(2)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  balance_writeback #(.RD_LAT(2), .MAX_RETRY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // RAM model: read latency g+1; bit 0 of a read is flipped when the mask bit
  // for (write pass, word) is set. Passes are counted by writes to word 0.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [7:0] mem  [4];
    logic [7:0] pipe [3];
    int         wp;
    logic [1:0] addr;

    assign addr     = {ap2_v[g], atype_v[g][0]};
    assign res_v[g] = pipe[g];

    always @(posedge clock) begin
      logic [7:0] rd;
      if (!start_v[g]) wp <= 0;
      else if (wren_v[g] && addr == 2'd0) wp <= wp + 1;
      if (wren_v[g]) mem[addr] <= din_v[g];
      rd = mem[addr];
      if (wp >= 1 && wp <= 3 && cm_v[g][4 * (wp - 1) + int'(addr)]) rd = rd ^ 8'h01;
      pipe[0] <= rd;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  function automatic int lat_of(input int s);
    return s + 1;
  endfunction

  function automatic int mr_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each pass writes the four bytes on consecutive cycles, then
  // spends lat+1 cycles per verified word until a corrupted word ends the pass.
  function automatic void model(input logic [10:0] a1, input logic [10:0] a2,
                                input logic [11:0] cm, input int lat, input int mr,
                                output int t_done, output bit err);
    int  t;
    int  amt;
    bit  bad;
    wr_t r;
    t = 0;
    exp_q.delete();
    t_done = 0;
    err    = 1'b1;
    for (int p = 0; p <= mr; p++) begin
      for (int w = 0; w < 4; w++) begin
        amt    = (w < 2) ? int'(a1) : int'(a2);
        r.cyc  = 16'(t + w + 1);
        r.p2   = (w >= 2);
        r.typ  = 2'(w % 2);
        r.data = 8'((w % 2 == 0) ? (amt % 256) : (amt / 256));
        exp_q.push_back(r);
      end
      t   += 4;
      bad  = 1'b0;
      for (int w = 0; w < 4 && !bad; w++) begin
        t += lat + 1;
        if (cm[4 * p + w]) bad = 1'b1;
      end
      if (!bad) begin
        t_done = t + 1;
        err    = 1'b0;
        return;
      end
    end
    t_done = t + 1;
  endfunction

  // Called at a negedge with the instance idle; returns at the negedge where
  // done or error is first seen (cycle count relative to the start cycle).
  task automatic run_txn(input int s, input logic [10:0] a1, input logic [10:0] a2,
                         input logic [11:0] cm, input bit perturb,
                         output int t_done, output bit err);
    wr_t r;
    act_q.delete();
    t_done     = -1;
    err        = 1'b0;
    cm_v[s]    = cm;
    p1_v[s]    = a1;
    p2_v[s]    = a2;
    start_v[s] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      if (k == 1) check("busy_first_write", {30'd0, busy_v[s], wren_v[s]}, 32'd3);
      if (wren_v[s]) begin
        r.cyc  = 16'(k);
        r.p2   = ap2_v[s];
        r.typ  = atype_v[s];
        r.data = din_v[s];
        act_q.push_back(r);
      end
      if (perturb && k == 2) begin
        p1_v[s] = ~a1;
        p2_v[s] = ~a2;
      end
      if (done_v[s] || err_v[s]) begin
        t_done = k;
        err    = err_v[s];
        check("done_busy_excl", {29'd0, done_v[s] & err_v[s], busy_v[s], wren_v[s]}, 32'd0);
        break;
      end
    end
  endtask

  task automatic compare_model(input int s, input logic [10:0] a1, input logic [10:0] a2,
                               input logic [11:0] cm, input int t_done, input bit err,
                               input string tag);
    int et;
    bit ee;
    int n;
    model(a1, a2, cm, lat_of(s), mr_of(s), et, ee);
    check({tag, "_cycle"}, t_done, et);
    check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    check({tag, "_nwr"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  // Status must hold while start is high, then clear one cycle after it drops.
  task automatic finish_txn(input int s, input bit exp_err, input string tag);
    @(negedge clock);
    check({tag, "_held"}, {30'd0, done_v[s], err_v[s]}, exp_err ? 32'd1 : 32'd2);
    start_v[s] = 1'b0;
    @(negedge clock);
    check({tag, "_clear"}, {29'd0, done_v[s], err_v[s], busy_v[s]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    int          t_done;
    bit          err;
    bit          seen;
    logic [31:0] bytes;
    logic [10:0] a1, a2;
    logic [11:0] cm;
    int          s;

    tbl[0] = '{11'd1000, 11'd47,   12'h000, 13, 1'b0, 4,  32'hE8032F00};
    tbl[1] = '{11'd2047, 11'd0,    12'h000, 13, 1'b0, 4,  32'hFF070000};
    tbl[2] = '{11'd0,    11'd2047, 12'h000, 13, 1'b0, 4,  32'h0000FF07};
    tbl[3] = '{11'd1000, 11'd47,   12'h004, 23, 1'b0, 8,  32'hE8032F00};
    tbl[4] = '{11'd1000, 11'd47,   12'h111, 19, 1'b1, 12, 32'hE8032F00};
    tbl[5] = '{11'd1000, 11'd47,   12'h888, 37, 1'b1, 12, 32'hE8032F00};
    tbl[6] = '{11'd1000, 11'd47,   12'h028, 33, 1'b0, 12, 32'hE8032F00};

    reset   = 1'b1;
    start_v = '0;
    p1_v    = '0;
    p2_v    = '0;
    cm_v    = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++)
      check("reset_outputs", {17'd0, busy_v[i], done_v[i], err_v[i], wren_v[i], ap2_v[i],
                              atype_v[i], din_v[i]}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed table on instance 0 (RD_LAT 1, MAX_RETRY 2).
    for (int v = 0; v < 7; v++) begin
      run_txn(0, tbl[v].a1, tbl[v].a2, tbl[v].cm, 1'b0, t_done, err);
      check($sformatf("tbl%0d_cycle", v), t_done, tbl[v].exp_done);
      check($sformatf("tbl%0d_err", v), {31'd0, err}, {31'd0, tbl[v].exp_err});
      check($sformatf("tbl%0d_nwr", v), act_q.size(), tbl[v].exp_wr);
      bytes = '0;
      for (int i = 0; i < 4 && i < act_q.size(); i++) bytes = {bytes[23:0], act_q[i].data};
      check($sformatf("tbl%0d_bytes", v), bytes, tbl[v].exp_bytes);
      compare_model(0, tbl[v].a1, tbl[v].a2, tbl[v].cm, t_done, err, $sformatf("tbl%0d", v));
      finish_txn(0, tbl[v].exp_err, $sformatf("tbl%0d", v));
    end

    // Abort: start drops during the second write cycle.
    cm_v[0]    = '0;
    p1_v[0]    = 11'd5;
    p2_v[0]    = 11'd6;
    start_v[0] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("abort_writing", {31'd0, wren_v[0]}, 32'd1);
    start_v[0] = 1'b0;
    @(negedge clock);
    check("abort_idle", {30'd0, wren_v[0], busy_v[0]}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done_v[0] || err_v[0] || busy_v[0]) seen = 1'b1;
    end
    check("abort_no_status", {31'd0, seen}, 32'd0);
    run_txn(0, 11'd1234, 11'd567, 12'h000, 1'b0, t_done, err);
    compare_model(0, 11'd1234, 11'd567, 12'h000, t_done, err, "after_abort");
    finish_txn(0, 1'b0, "after_abort");

    // Reset during verify on instance 1 (RD_LAT 2), then a store of new values.
    cm_v[1]    = '0;
    p1_v[1]    = 11'd300;
    p2_v[1]    = 11'd400;
    start_v[1] = 1'b1;
    repeat (7) @(negedge clock);
    check("rst_mid_busy", {31'd0, busy_v[1]}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_outputs", {17'd0, busy_v[1], done_v[1], err_v[1], wren_v[1], ap2_v[1],
                              atype_v[1], din_v[1]}, 32'd0);
    reset      = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clock);
    run_txn(1, 11'd1111, 11'd222, 12'h000, 1'b0, t_done, err);
    compare_model(1, 11'd1111, 11'd222, 12'h000, t_done, err, "after_reset");
    finish_txn(1, 1'b0, "after_reset");

    // Random amounts and corruption patterns on both instances.
    for (int it = 0; it < 40; it++) begin
      s  = int'($urandom_range(0, 1));
      a1 = 11'($urandom);
      a2 = 11'($urandom);
      cm = '0;
      for (int b = 0; b < 12; b++) if ($urandom_range(0, 5) == 0) cm[b] = 1'b1;
      run_txn(s, a1, a2, cm, 1'b1, t_done, err);
      compare_model(s, a1, a2, cm, t_done, err, $sformatf("rnd%0d", it));
      finish_txn(s, err, $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
